// File: rtl/fsk_period_demod.sv
// FSK period demodulator: times synchronized Sig_in rising edges, thresholds and majority-votes each period.
// Define FSK_DEMOD_GLITCH_EN to add i_min_period, which ignores edges arriving too soon after the last one.
module fsk_period_demod #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int VOTE_N      = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig_in,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic [CNT_W-1:0] i_timeout,
`ifdef FSK_DEMOD_GLITCH_EN
  input  logic [CNT_W-1:0] i_min_period,
`endif
  output logic             o_bit_out,
  output logic             o_bit_valid,
  output logic [CNT_W-1:0] o_period_out,
  output logic             o_lost
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_FIRST   = 2'd2;
  localparam logic [1:0] ST_TRACK   = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_count;
  logic [VOTE_N-1:0]      r_hist;
  logic                   r_bit;
  logic                   r_valid;
  logic [CNT_W-1:0]       r_period;
  logic                   r_lost;

  logic                   w_detect;
  logic                   w_take;
  logic                   w_raw;
  logic                   w_timeout;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [VOTE_N-1:0]      w_hist_shift;
  logic [3:0]             w_ones;
  logic                   w_maj;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_detect = r_sync[SYNC_STAGES-1] & ~r_prev;
`ifdef FSK_DEMOD_GLITCH_EN
    w_take   = w_detect & (r_count >= i_min_period);
`else
    w_take   = w_detect;
`endif
    w_raw     = (r_count < i_thresh);
    w_timeout = (i_timeout != '0) && (r_count == i_timeout);
    w_cnt_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
  end

  // Vote over the history as it will be after the new raw bit is shifted in.
  always_comb begin
    w_hist_shift    = '0;
    w_hist_shift[0] = w_raw;
    for (int unsigned i = 1; i < VOTE_N; i++) begin
      w_hist_shift[i] = r_hist[i-1];
    end
    w_ones = '0;
    for (int unsigned i = 0; i < VOTE_N; i++) begin
      w_ones = w_ones + {3'b000, w_hist_shift[i]};
    end
    w_maj = (w_ones > 4'(VOTE_N / 2));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_hist   <= '0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_lost   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_lost  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ACQUIRE;
            r_count <= '0;
          end
          ST_ACQUIRE: begin
            if (w_detect) begin
              r_count <= CNT_W'(1);
              r_state <= ST_FIRST;
            end
          end
          default: begin
            // A valid detect outranks a coincident timeout.
            if (w_take) begin
              r_count  <= CNT_W'(1);
              r_period <= r_count;
              r_valid  <= 1'b1;
              r_lost   <= 1'b0;
              r_state  <= ST_TRACK;
              if (r_state == ST_FIRST) begin
                r_hist <= {VOTE_N{w_raw}};
                r_bit  <= w_raw;
              end else begin
                r_hist <= w_hist_shift;
                r_bit  <= w_maj;
              end
            end else if (w_timeout) begin
              r_lost  <= 1'b1;
              r_state <= ST_ACQUIRE;
              r_hist  <= '0;
              r_count <= '0;
            end else begin
              r_count <= w_cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign o_bit_out    = r_bit;
  assign o_bit_valid  = r_valid;
  assign o_period_out = r_period;
  assign o_lost       = r_lost;

endmodule

// File: tb/tb_fsk_period_demod.sv
// Self-checking bench for fsk_period_demod: timestamp-based reference model plus directed literal checks.
module tb_fsk_period_demod;
  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int VN    = 3;
  localparam int MAXC  = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             sig = 1'b0;
  logic [CNT_W-1:0] thresh  = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic [CNT_W-1:0] minp    = '0;
  logic             o_bit;
  logic             o_valid;
  logic [CNT_W-1:0] o_period;
  logic             o_lost;

  always #5 clk = ~clk;

  fsk_period_demod #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC),
    .VOTE_N(VN)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_sig_in(sig),
    .i_thresh(thresh),
    .i_timeout(timeout),
`ifdef FSK_DEMOD_GLITCH_EN
    .i_min_period(minp),
`endif
    .o_bit_out(o_bit),
    .o_bit_valid(o_valid),
    .o_period_out(o_period),
    .o_lost(o_lost)
  );

  int compared = 0;
  int mism     = 0;

  // Reference model: detects are input rises delayed by SYNC+1 edges, periods are timestamp differences.
  int  n = 0;
  bit  s_prev = 1'b0;
  int  pend[$];
  bit  armed = 1'b0, have_ref = 1'b0;
  int  last = 0;
  int  votes[$];
  bit  exp_bit = 1'b0, exp_valid = 1'b0, exp_lost = 1'b0;
  int  exp_period = 0;
  bit  det, take;
  int  cnt, raw, ones;

  always @(posedge clk or posedge rst) begin
    n++;
    if (rst) begin
      s_prev = 1'b0; pend.delete(); armed = 1'b0; have_ref = 1'b0; votes.delete();
      exp_bit = 1'b0; exp_valid = 1'b0; exp_lost = 1'b0; exp_period = 0;
    end else begin
      det = 1'b0;
      if (pend.size() > 0 && pend[0] == n) begin
        det = 1'b1;
        void'(pend.pop_front());
      end
      if (sig && !s_prev) pend.push_back(n + SYNC);
      s_prev = sig;
      exp_valid = 1'b0;
      if (!en) begin
        armed = 1'b0; have_ref = 1'b0; exp_lost = 1'b0; votes.delete();
      end else if (!armed) begin
        armed = 1'b1;
      end else if (!have_ref) begin
        if (det) begin have_ref = 1'b1; last = n; end
      end else begin
        cnt = n - last;
        if (cnt > MAXC) cnt = MAXC;
`ifdef FSK_DEMOD_GLITCH_EN
        take = det && (cnt >= int'(minp));
`else
        take = det;
`endif
        if (take) begin
          raw = (cnt < int'(thresh)) ? 1 : 0;
          if (votes.size() == 0) begin
            repeat (VN) votes.push_back(raw);
          end else begin
            votes.push_back(raw);
            void'(votes.pop_front());
          end
          ones = 0;
          foreach (votes[i]) ones += votes[i];
          exp_bit = (ones * 2 > VN); exp_period = cnt; exp_valid = 1'b1; exp_lost = 1'b0;
          last = n;
        end else if (timeout != 0 && cnt == int'(timeout)) begin
          exp_lost = 1'b1; have_ref = 1'b0; votes.delete();
        end
      end
    end
  end

  int valid_cnt = 0;
  bit bitlog[$];
  int last_valid_t = 0, lost_rise_t = 0;
  bit lost_q = 1'b0;

  always @(negedge clk) begin
    compared++;
    if (o_bit !== exp_bit || o_valid !== exp_valid || o_period !== CNT_W'(exp_period) || o_lost !== exp_lost) begin
      mism++;
      $display("FAIL cycle_check t=%0t: dut bit=%0b valid=%0b period=%0d lost=%0b, model bit=%0b valid=%0b period=%0d lost=%0b",
               $time, o_bit, o_valid, o_period, o_lost, exp_bit, exp_valid, exp_period, exp_lost);
    end
    if (o_valid === 1'b1) begin
      valid_cnt++;
      bitlog.push_back(o_bit);
      last_valid_t = n;
    end
    if (o_lost === 1'b1 && !lost_q) lost_rise_t = n;
    lost_q = (o_lost === 1'b1);
  end

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mism++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wave(input int per, input int hi, input int num);
    repeat (num) begin
      sig = 1'b1; tick(hi);
      sig = 1'b0; tick(per - hi);
    end
  endtask

  int sz, per, hi;

  initial begin
    tick(3); #2 rst = 1'b0;
    tick(2);
    check("reset_bit", int'(o_bit), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_period", int'(o_period), 0);
    check("reset_lost", int'(o_lost), 0);

    thresh = 16'd100; timeout = '0; en = 1'b1; tick(2);
    valid_cnt = 0;
    wave(50, 25, 6);
    check("p50_valid_count", valid_cnt, 5);
    check("p50_period", int'(o_period), 50);
    check("p50_bit", int'(o_bit), 1);

    wave(150, 75, 3);
    sz = bitlog.size();
    check("p150_first_bit", int'(bitlog[sz-2]), 1);
    check("p150_second_bit", int'(bitlog[sz-1]), 0);
    check("p150_period", int'(o_period), 150);

    wave(100, 50, 3);
    check("p100_bit", int'(o_bit), 0);
    check("p100_period", int'(o_period), 100);
    wave(99, 40, 4);
    check("p99_bit", int'(o_bit), 1);
    check("p99_period", int'(o_period), 99);

    en = 1'b0; tick(2); timeout = 16'd500; en = 1'b1; tick(2);
    wave(50, 25, 4);
    tick(600);
    check("timeout_lost", int'(o_lost), 1);
    check("timeout_delay", lost_rise_t - last_valid_t, 500);
    valid_cnt = 0;
    wave(50, 25, 3);
    check("restart_valid_count", valid_cnt, 2);
    check("restart_lost", int'(o_lost), 0);
    check("restart_bit", int'(o_bit), 1);

    sig = 1'b1; tick(10);
    #2 rst = 1'b1;
    #1;
    check("midreset_bit", int'(o_bit), 0);
    check("midreset_valid", int'(o_valid), 0);
    check("midreset_period", int'(o_period), 0);
    check("midreset_lost", int'(o_lost), 0);
    sig = 1'b0;
    tick(1); #2 rst = 1'b0;
    tick(2);

    wave(50, 25, 5);
    // Drop EN exactly on the edge whose detect would otherwise produce a strobe.
    sig = 1'b1; tick(2); en = 1'b0; valid_cnt = 0;
    tick(23); sig = 1'b0; tick(25);
    wave(50, 25, 3);
    check("en_off_valids", valid_cnt, 0);
    check("en_off_bit", int'(o_bit), 1);
    check("en_off_period", int'(o_period), 50);
    check("en_off_lost", int'(o_lost), 0);

`ifdef FSK_DEMOD_GLITCH_EN
    timeout = '0; minp = 16'd20; en = 1'b1; tick(2);
    repeat (6) begin
      sig = 1'b1; tick(5); sig = 1'b0; tick(5);
      sig = 1'b1; tick(5); sig = 1'b0; tick(35);
    end
    check("glitch_period", int'(o_period), 50);
    check("glitch_bit", int'(o_bit), 1);
    en = 1'b0; tick(2); minp = '0;
`endif

    for (int r = 0; r < 12; r++) begin
      en = 1'b0; tick($urandom_range(1, 4));
      thresh  = CNT_W'($urandom_range(20, 200));
      timeout = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(60, 400));
      en = 1'b1; tick($urandom_range(0, 3));
      for (int s = 0; s < 8; s++) begin
        per = $urandom_range(8, 220);
        if ($urandom_range(0, 3) == 0) per = int'(thresh) + $urandom_range(0, 1);
        hi = $urandom_range(1, per - 1);
        wave(per, hi, $urandom_range(1, 5));
        if ($urandom_range(0, 4) == 0) tick($urandom_range(50, 450));
      end
    end

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/fsk_period_demod.md
Name: fsk_period_demod

Overview:
FSK receiver for the function generator's FSK path. It recovers the mark/space control bit from an external or looped-back FSK square wave by measuring the clock count between rising edges. Each period is compared against a frequency threshold and majority-voted. It provides the loopback check for the FSK transmitter and feeds the external-trigger qualification logic.

Parameters:
CNT_W, 24, width of the period counter, Thresh, Timeout and Period_out.
SYNC_STAGES, 2, number of flops in the Sig_in synchronizer (minimum 2).
VOTE_N, 3, majority-vote depth. Must be odd, 1..7.

Ports:
Clock  in  1  system clock; all logic rises on posedge.
Reset  in  1  asynchronous, active-high reset.
EN  in  1  demodulator enable; low forces IDLE.
Sig_in  in  1  asynchronous FSK square wave.
Thresh  in  CNT_W  period threshold in clocks. Period < Thresh gives bit 1 (mark, high frequency).
Timeout  in  CNT_W  loss-of-signal limit in clocks; 0 disables it.
Bit_out  out  1  recovered, voted FSK bit.
Bit_valid  out  1  one-cycle strobe; Bit_out/Period_out updated this cycle.
Period_out  out  CNT_W  last measured period in clocks.
Lost  out  1  loss-of-signal flag.

Behaviour:
- Reset (async, high):
  - state=IDLE, counter=0, vote history=0.
  - Bit_out=0, Bit_valid=0, Period_out=0, Lost=0.
- Input path: Sig_in → SYNC_STAGES flops → one edge-detect flop. A rise is "detected" when synchronized=1 and previous=0. Sig_in rise to detect cycle = SYNC_STAGES+1 clocks.
- Counter:
  - Loads 1 on the cycle after a detect and increments each cycle with no detect.
  - Saturates at all-ones; never wraps.
  - For edges P clocks apart, the counter value seen in the second detect cycle is P.
- States:
  - IDLE: entered while EN=0. Counter held at 0, Lost cleared, Bit_out and Period_out hold. EN=1 → ACQUIRE.
  - ACQUIRE: first detect starts the counter, no measurement → FIRST.
  - FIRST: on detect, measure P. raw=(P<Thresh). Fill all VOTE_N history bits with raw. Bit_out=raw, Period_out=P, Bit_valid=1, Lost=0 → TRACK.
  - TRACK: on detect, measure P and shift raw into history. Bit_out=majority(history incl. new raw), Period_out=P, Bit_valid=1, Lost=0.
- Registered update: outputs change on the clock edge following the detect cycle, so Bit_valid is high for exactly one cycle then.
- Threshold: P==Thresh gives raw=0. Thresh=0 gives raw always 0.
- Timeout: in FIRST/TRACK, if counter==Timeout (Timeout≠0) with no detect:
  - Lost=1 on the next edge, state → ACQUIRE.
  - History cleared; Bit_out and Period_out hold.
  - Lost stays high until the next Bit_valid or IDLE.
- Simultaneous events:
  - Detect in the same cycle as counter==Timeout: the detect wins and the measurement is taken.
  - EN falling in a detect cycle: IDLE wins and no Bit_valid is issued.
- Mid-operation: async Reset at any point returns to reset values immediately. Leaving and re-entering via EN restarts at ACQUIRE.
- Thresh/Timeout are sampled combinationally each cycle and must be held stable by software while EN=1.

Optional Feature:
FSK_DEMOD_GLITCH_EN
- Defined:
  - Adds input port Min_period (CNT_W).
  - In FIRST/TRACK, a detect with counter < Min_period is ignored: no measurement, counter keeps counting.
  - Min_period=0 means no filtering.
- Undefined: Min_period port absent; every detect is measured.

Test Plan:
- CNT_W=16, VOTE_N=3, Thresh=100, Timeout=0, EN=1, square wave period 50 → first Bit_valid at the second edge with Period_out=50, Bit_out=1; one strobe per 50 clocks thereafter.
- Period 50 steady, then switch to period 150 → first 150 measurement keeps Bit_out=1 (history 1,1,0); second gives Bit_out=0, Period_out=150.
- Period exactly 100 → Bit_out=0. Period 99 → Bit_out=1.
- Timeout=500, period 50, then hold Sig_in low → Lost=1 on the clock after the counter reaches 500; no Bit_valid. Restart period 50 → Lost clears on the next Bit_valid, which is 2 edges after restart.
- Assert Reset for 1 cycle mid-period with Bit_out=1 → all outputs 0 immediately. Deassert EN mid-stream → Bit_valid stops, outputs hold, Lost=0.
- With FSK_DEMOD_GLITCH_EN, Min_period=20, period-50 wave plus a 5-clock extra pulse → glitch edge ignored; Period_out=50 sequence is unchanged.
